// File: rtl/div_pkg.sv
// Shared state encoding, constants and sign helpers for the sequential signed divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  function automatic logic [DIV_WIDTH-1:0] div_neg(input logic [DIV_WIDTH-1:0] x);
    return {DIV_WIDTH{1'b0}} - x;
  endfunction

  // The most negative value maps onto itself, which is the correct magnitude when read unsigned.
  function automatic logic [DIV_WIDTH-1:0] div_abs(input logic [DIV_WIDTH-1:0] x);
    if (x[DIV_WIDTH-1]) begin
      return div_neg(x);
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_restore_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // Shift the partial remainder in, then subtract the divisor when it fits.
  always_comb begin
    shifted_s = {rem, quo[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, divisor};
    rem_next  = shifted_s[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], 1'b0};
    if (shifted_s >= {1'b0, divisor}) begin
      rem_next = diff_s[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted_s[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_32_seq.sv
// Sequential 32-bit signed divider: Y_lo = quotient, Y_hi = remainder, one quotient bit per clock.
// Optional DIV_FAST_PATH_EN: zero-quotient divisions finish straight from IDLE.
module div_32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y_hi,
  output logic [WIDTH-1:0] Y_lo,
  output logic             C,
  output logic             V,
  output logic             N,
  output logic             Z
);

  localparam int               CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);
  localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] rem_r, quo_r, dvsr_r;
  logic [WIDTH-1:0] y_hi_r, y_lo_r;
  logic             neg_quo_r, neg_rem_r, ovf_r;
  logic             busy_r, done_r, v_r, n_r, z_r;
  logic [WIDTH-1:0] s_abs_s, t_abs_s, rem_step_s, quo_step_s, quo_fix_s, rem_fix_s;
  logic             div_zero_s, short_cut_s;

  assign s_abs_s    = div_abs(S);
  assign t_abs_s    = div_abs(T);
  assign div_zero_s = (T == ZERO);
  assign quo_fix_s  = neg_quo_r ? div_neg(quo_r) : quo_r;
  assign rem_fix_s  = neg_rem_r ? div_neg(rem_r) : rem_r;

`ifdef DIV_FAST_PATH_EN
  assign short_cut_s = !div_zero_s && ((S == ZERO) || (s_abs_s < t_abs_s));
`else
  assign short_cut_s = 1'b0;
`endif

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (dvsr_r),
    .rem_next (rem_step_s),
    .quo_next (quo_step_s)
  );

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (div_zero_s || short_cut_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = CALC;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == LAST_ITER) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIX:     state_nxt_s = DONE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, iteration, sign fix-up and result/flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r     <= CNT_ZERO;
      rem_r     <= ZERO;
      quo_r     <= ZERO;
      dvsr_r    <= ZERO;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      ovf_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      y_hi_r    <= ZERO;
      y_lo_r    <= ZERO;
      v_r       <= 1'b0;
      n_r       <= 1'b0;
      z_r       <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == CALC) || (state_nxt_s == FIX);
      done_r <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            rem_r     <= ZERO;
            quo_r     <= s_abs_s;
            dvsr_r    <= t_abs_s;
            cnt_r     <= CNT_ZERO;
            neg_quo_r <= S[WIDTH-1] ^ T[WIDTH-1];
            neg_rem_r <= S[WIDTH-1];
            ovf_r     <= (S == MIN_NEG) && (T == ALL_ONES);
            if (div_zero_s) begin
              y_lo_r <= DIV_ZERO_QUO;
              y_hi_r <= S;
              v_r    <= 1'b1;
              n_r    <= 1'b1;
              z_r    <= 1'b0;
            end else if (short_cut_s) begin
              y_lo_r <= ZERO;
              y_hi_r <= S;
              v_r    <= 1'b0;
              n_r    <= 1'b0;
              z_r    <= 1'b1;
            end
          end
        end
        CALC: begin
          rem_r <= rem_step_s;
          quo_r <= quo_step_s;
          cnt_r <= cnt_r + CNT_ONE;
        end
        FIX: begin
          y_lo_r <= quo_fix_s;
          y_hi_r <= rem_fix_s;
          v_r    <= ovf_r;
          n_r    <= quo_fix_s[WIDTH-1];
          z_r    <= (quo_fix_s == ZERO);
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign Y_hi = y_hi_r;
  assign Y_lo = y_lo_r;
  assign C    = 1'b0;
  assign V    = v_r;
  assign N    = n_r;
  assign Z    = z_r;

endmodule

// File: tb/tb_div_32_seq.sv
// Self-checking bench for div_32_seq against a plain signed-arithmetic reference model.
// Expected latencies follow DIV_FAST_PATH_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_div_32_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] S = 32'd0;
  logic [31:0] T = 32'd0;
  logic        busy, done, C, V, N, Z;
  logic [31:0] Y_hi, Y_lo;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] last_lo = 32'd0;

  always #5 clk = ~clk;

  div_32_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .S     (S),
    .T     (T),
    .busy  (busy),
    .done  (done),
    .Y_hi  (Y_hi),
    .Y_lo  (Y_lo),
    .C     (C),
    .V     (V),
    .N     (N),
    .Z     (Z)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Truncating signed division; edges from start edge to done rising.
  function automatic void model(input logic [31:0] s, input logic [31:0] t,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic v, output int lat);
    int si, ti;
    si = s;
    ti = t;
    if (t == 32'd0) begin
      q = 32'hFFFF_FFFF; r = s; v = 1'b1; lat = 0;
    end else if (s == 32'h8000_0000 && t == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; v = 1'b1; lat = 33;
    end else begin
      q = si / ti; r = si % ti; v = 1'b0; lat = 33;
`ifdef DIV_FAST_PATH_EN
      if (q == 32'd0) lat = 0;
`endif
    end
  endfunction

  task automatic run_div(input logic [31:0] s, input logic [31:0] t, input bit poke);
    logic [31:0] eq, er;
    logic        ev;
    int          elat, edges, busy_cnt;
    string       tg;
    model(s, t, eq, er, ev, elat);
    tg = $sformatf("%0h/%0h", s, t);
    @(negedge clk);
    S = s; T = t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; S = $urandom; T = $urandom;
    edges = 0; busy_cnt = 0;
    while (!done && edges < 60) begin
      if (busy) busy_cnt++;
      if (edges == 3 && elat > 3) check({tg, " hold"}, Y_lo, last_lo);
      if (poke && edges == 5) begin
        start = 1'b1; S = $urandom; T = 32'd0;
        @(posedge clk); #1;
      end else begin
        @(posedge clk); #1;
      end
      start = 1'b0;
      edges++;
    end
    check({tg, " latency"}, 32'(edges), 32'(elat));
    check({tg, " busy"}, 32'(busy_cnt), 32'(elat));
    check({tg, " quo"}, Y_lo, eq);
    check({tg, " rem"}, Y_hi, er);
    check({tg, " V"}, 32'(V), 32'(ev));
    check({tg, " N"}, 32'(N), 32'(eq[31]));
    check({tg, " Z"}, 32'(Z), 32'(eq == 32'd0));
    check({tg, " C"}, 32'(C), 32'd0);
    @(posedge clk); #1;
    check({tg, " pulse"}, 32'(done), 32'd0);
    last_lo = eq;
  endtask

  initial begin
    logic [31:0] s, t;
    bit          saw_done;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst quo", Y_lo, 32'd0);
    check("rst rem", Y_hi, 32'd0);
    check("rst flags", {28'd0, C, V, N, Z}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    run_div(32'd100, 32'd7, 1'b0);
    run_div(32'hFFFF_FF9C, 32'd7, 1'b0);
    run_div(32'd100, 32'hFFFF_FFF9, 1'b0);
    run_div(32'd5, 32'd0, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div(32'd3, 32'd10, 1'b0);
    run_div(32'd1000, 32'd3, 1'b1);
    run_div(32'd0, 32'hFFFF_FFFB, 1'b0);
    run_div(32'hFFFF_FFFD, 32'd10, 1'b0);
    run_div(32'h7FFF_FFFF, 32'd1, 1'b0);
    run_div(32'h8000_0000, 32'd1, 1'b0);
    run_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0);

    // Abort: ignored restart at cycle 5, reset at cycle 10.
    saw_done = 1'b0;
    @(negedge clk);
    S = 32'd1000; T = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 4) begin start = 1'b1; S = 32'd7; T = 32'd0; end
      if (k == 5) start = 1'b0;
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    reset = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort quo", Y_lo, 32'd0);
    check("abort rem", Y_hi, 32'd0);
    check("abort flags", {28'd0, C, V, N, Z}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("abort no done", 32'(saw_done), 32'd0);
    last_lo = 32'd0;
    run_div(32'd1000, 32'd3, 1'b0);

    for (int k = 0; k < 24; k++) begin
      s = $urandom;
      case (k % 4)
        0: t = $urandom;
        1: t = $urandom_range(1, 20);
        2: t = 32'd0 - $urandom_range(1, 300);
        default: begin t = $urandom >> 12; s = s >> $urandom_range(0, 24); end
      endcase
      if (k == 13) t = 32'd0;
      run_div(s, t, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/div_32_seq.md
Name: div_32_seq

Overview:
- Sequential 32-bit signed integer divider; the inverse companion of the integer datapath's 32x32 multiplier.
- Same result/flag shape as the multiplier: Y_hi = remainder, Y_lo = quotient, flags C/V/N/Z.
- Restoring shift-subtract, one quotient bit per clock, start/busy/done handshake so the datapath controller can stall on DIV.

Parameters:
- WIDTH, 32, operand width. Only 32 is verified; counter width is derived as clog2(WIDTH)+1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- S  input  WIDTH  dividend (two's complement)
- T  input  WIDTH  divisor (two's complement)
- busy  output  1  high in CALC and FIX
- done  output  1  one-cycle pulse, high while in DONE
- Y_hi  output  WIDTH  remainder
- Y_lo  output  WIDTH  quotient
- C  output  1  carry flag, always 0
- V  output  1  divide-by-zero or overflow
- N  output  1  quotient sign, Y_lo[31]
- Z  output  1  quotient == 0

Behaviour:
- Reset (async, active-low): state=IDLE, all outputs 0, iteration counter 0.
- IDLE:
  - start=1 captures |S|, |T|, sign(S) and sign(S)^sign(T); goes to CALC; counter=0.
  - If T==0: go directly to DONE with Y_lo=0xFFFFFFFF, Y_hi=S, V=1, N=1, Z=0. done is high in the cycle after the start edge.
- CALC: one restoring step per edge.
  - Shift {rem,quo} left 1.
  - If rem >= |T|: rem -= |T| and quotient LSB=1; else LSB=0.
  - Exactly 32 edges, then FIX.
- FIX: one edge.
  - Negate the quotient if the signs differ.
  - Negate the remainder if S was negative.
  - Truncate toward zero; remainder carries the dividend's sign.
  - Load Y_hi/Y_lo and flags, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Latency: start edge E0, CALC E1..E32, FIX E33, done high between E33 and E34.
- Output hold: Y_hi/Y_lo/flags hold their last result until the next FIX or divide-by-zero load; they are not cleared on a new start.
- Overflow: S=0x80000000 with T=0xFFFFFFFF gives Y_lo=0x80000000, Y_hi=0, V=1. This case is detected at capture and the normal iteration path is used.
- Flags: V=0 for all other cases; C=0 always; N=Y_lo[31]; Z=(Y_lo==0).
- start while busy or in DONE is ignored; there is no queueing.
- Reset asserted mid-CALC/FIX aborts immediately. Outputs return to 0 and no done pulse is issued.
- S and T are not required stable after E0.

Optional Feature:
- DIV_FAST_PATH_EN defined: in IDLE, if S==0 or |S|<|T| (T nonzero), skip CALC/FIX and load Y_lo=0, Y_hi=S, Z=1, V=0 directly. done is then high in the cycle after E0.
- Undefined: these cases take the full 33-cycle path with identical results.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, CALC, FIX, DONE}
  - WIDTH default constant
  - DIV_ITERS=32
  - DIV_ZERO_QUO=32'hFFFFFFFF
- One combinational sub-module, div_restore_step: inputs rem, quo, divisor; outputs next rem/quo for one iteration. It is instantiated once, and the FSM and sign handling stay in div_32_seq.

Test Plan:
- S=100, T=7, pulse start -> done exactly 33 cycles after the start edge; Y_lo=14, Y_hi=2, V=0, N=0, Z=0, busy high for 33 cycles.
- S=-100 (0xFFFFFF9C), T=7 -> Y_lo=0xFFFFFFF2, Y_hi=0xFFFFFFFE, N=1; then S=100, T=-7 -> Y_lo=0xFFFFFFF2, Y_hi=2.
- S=5, T=0 -> done 1 cycle after start; Y_lo=0xFFFFFFFF, Y_hi=5, V=1, N=1.
- S=0x80000000, T=0xFFFFFFFF -> Y_lo=0x80000000, Y_hi=0, V=1, N=1.
- S=3, T=10 -> Y_lo=0, Y_hi=3, Z=1. Latency is 33 cycles without DIV_FAST_PATH_EN and 1 cycle with it.
- Start 1000/3, reassert start at cycle 5 (ignored), drop reset at cycle 10 -> outputs 0, busy=0, no done. Restart 1000/3 -> Y_lo=333, Y_hi=1.
